// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning HI/LO for the E stage
//
// Purpose: accepts mult/multu/div/divu/mthi/mtlo from E, counts out a fixed
// latency per operation, writes HI/LO on the last busy edge and requests a
// pipeline stall while a D-stage md-type instruction would see stale HI/LO.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start, op[1:0]    E-stage mult(00)/multu(01)/div(10)/divu(11) valid
//   mt_hi, mt_lo      E-stage mthi/mtlo, write A into HI/LO when idle
//   A, B [31:0]       forwarded rs/rt operands
//   md_use_D          D-stage instruction touches the md unit
//   busy              operation in flight
//   HI, LO [31:0]     architectural HI/LO registers
//   md_stall          combinational stall request to the hazard unit
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    // Multiply: extend both operands to 64 bits (sign or zero per op) so one
    // unsigned 64-bit multiply yields the correct low 64 product bits.
    logic [63:0] ext_a, ext_b, prod;

    // Divide on magnitudes so the -2^31 / -1 case wraps to 0x80000000 cleanly
    // instead of relying on signed-overflow behaviour of the operator.
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, safe_b;
    logic [31:0] uquo, urem, quo, rem;

    always_comb begin
        ext_a = {(op_q[0] ? 32'h0 : {32{a_q[31]}}), a_q};
        ext_b = {(op_q[0] ? 32'h0 : {32{b_q[31]}}), b_q};
        prod  = ext_a * ext_b;

        neg_a  = ~op_q[0] & a_q[31];
        neg_b  = ~op_q[0] & b_q[31];
        mag_a  = neg_a ? (32'h0 - a_q) : a_q;
        mag_b  = neg_b ? (32'h0 - b_q) : b_q;
        // Result is discarded when B==0; the guard just keeps the divider defined.
        safe_b = (mag_b == 32'h0) ? 32'h1 : mag_b;
        uquo   = mag_a / safe_b;
        urem   = mag_a % safe_b;
        quo    = (neg_a ^ neg_b) ? (32'h0 - uquo) : uquo;
        rem    = neg_a ? (32'h0 - urem) : urem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // start takes priority over a coincident mthi/mtlo
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else begin
                    if (mt_hi) hi_d = A;
                    if (mt_lo) lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'h0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_stall = md_use_D & (start | busy);

endmodule
